pwm_setpoint_ctrl: RTL and testbench

Sequences the operating point applied to the PWM datapath (duty decoder / comparator / period counter).
- Inputs: raw current and frequency level requests from the tap up/down selectors.
- Outputs: "applied" levels that change only at PWM period boundaries.
- Current ramps one level per RAMP_PERIODS periods (soft start / soft stop).
- A frequency change first drains the current to 0, switches frequency, then ramps current back.

---
 rtl/pwm_ctrl_pkg.sv | 16 +
 rtl/ramp_tick.sv | 31 +++
 rtl/pwm_setpoint_ctrl.sv | 112 +++++++++++
 tb/tb_pwm_setpoint_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM operating-point sequencer: state encoding and
// level-code sizing.
package pwm_ctrl_pkg;

  localparam int DEF_LEVEL_W = 3;
  localparam int LEVEL_MAX   = (1 << DEF_LEVEL_W) - 1;

  typedef enum logic [2:0] {
    IDLE,
    TRACK,
    RAMP,
    DRAIN,
    SWITCH
  } state_t;

endpackage

// File: rtl/ramp_tick.sv
// Period-end divider: emits a one-cycle step on every RAMP_PERIODS-th period_end
// pulse since the last clear.
module ramp_tick #(
  parameter int RAMP_PERIODS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic period_end,
  output logic step
);

  localparam int CNT_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_PERIODS - 1);

  logic [CNT_W-1:0] cnt_q;

  // Combinational so the sequencer acts on the same edge that completes the count.
  assign step = period_end && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (period_end) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_setpoint_ctrl.sv
// Operating-point sequencer for the PWM datapath: soft-ramps the applied current
// level and drains it to zero around every frequency change.
module pwm_setpoint_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int RAMP_PERIODS = 16,
  parameter int LEVEL_W      = DEF_LEVEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               period_end,
  input  logic [LEVEL_W-1:0] corriente_req,
  input  logic [LEVEL_W-1:0] frecuencia_req,
  output logic [LEVEL_W-1:0] corriente_apl,
  output logic [LEVEL_W-1:0] frecuencia_apl,
  output logic               update_strobe,
  output logic               busy,
  output logic               at_target
);

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] corr_q, corr_d;
  logic [LEVEL_W-1:0] freq_q, freq_d;
  logic               strobe_q;
  logic               step;
  logic               clr;
  logic               freq_mismatch;

  // One level toward the target; never passes it, so no wrap in either direction.
  function automatic logic [LEVEL_W-1:0] step_toward(input logic [LEVEL_W-1:0] cur,
                                                     input logic [LEVEL_W-1:0] tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    else                return cur;
  endfunction

  function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] cur);
    return (cur == '0) ? cur : cur - 1'b1;
  endfunction

  assign freq_mismatch = (frecuencia_req != freq_q);
  assign clr           = !enable || (state_d != state_q);

  ramp_tick #(
    .RAMP_PERIODS(RAMP_PERIODS)
  ) u_ramp_tick (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .period_end (period_end),
    .step       (step)
  );

  always_comb begin
    state_d = state_q;
    corr_d  = corr_q;
    freq_d  = freq_q;
    if (!enable) begin
      state_d = IDLE;
      corr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = freq_mismatch ? SWITCH : RAMP;
        end
        TRACK: begin
          if (freq_mismatch)                state_d = (corr_q == '0) ? SWITCH : DRAIN;
          else if (corriente_req != corr_q) state_d = RAMP;
        end
        RAMP: begin
          if (freq_mismatch)                state_d = (corr_q == '0) ? SWITCH : DRAIN;
          else if (corriente_req == corr_q) state_d = TRACK;
          else if (step)                    corr_d  = step_toward(corr_q, corriente_req);
        end
        DRAIN: begin
          if (corr_q == '0) state_d = SWITCH;
          else if (step)    corr_d  = sat_dec(corr_q);
        end
        SWITCH: begin
          // Frequency only moves with the output already at zero current.
          if (period_end) begin
            freq_d  = frecuencia_req;
            state_d = RAMP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      corr_q   <= '0;
      freq_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      corr_q   <= corr_d;
      freq_q   <= freq_d;
      strobe_q <= (corr_d != corr_q) || (freq_d != freq_q);
    end
  end

  assign corriente_apl  = corr_q;
  assign frecuencia_apl = freq_q;
  assign update_strobe  = strobe_q;
  assign busy           = (state_q == RAMP) || (state_q == DRAIN) || (state_q == SWITCH);
  assign at_target      = (state_q == TRACK);

endmodule

// File: tb/tb_pwm_setpoint_ctrl.sv
// Directed bench for pwm_setpoint_ctrl: RAMP_PERIODS=2 instance for the main
// scenarios, RAMP_PERIODS=1 instance for per-period stepping and saturation.
module tb_pwm_setpoint_ctrl;
  import pwm_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       enable, period_end;
  logic [2:0] corriente_req, frecuencia_req;
  logic [2:0] corriente_apl, frecuencia_apl;
  logic       update_strobe, busy, at_target;

  logic       enable1, period_end1;
  logic [2:0] corriente_req1, frecuencia_req1;
  logic [2:0] corriente_apl1, frecuencia_apl1;
  logic       update_strobe1, busy1, at_target1;

  int errors = 0;
  int checks = 0;

  pwm_setpoint_ctrl #(.RAMP_PERIODS(2), .LEVEL_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period_end(period_end),
    .corriente_req(corriente_req), .frecuencia_req(frecuencia_req),
    .corriente_apl(corriente_apl), .frecuencia_apl(frecuencia_apl),
    .update_strobe(update_strobe), .busy(busy), .at_target(at_target)
  );

  pwm_setpoint_ctrl #(.RAMP_PERIODS(1), .LEVEL_W(3)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .period_end(period_end1),
    .corriente_req(corriente_req1), .frecuencia_req(frecuencia_req1),
    .corriente_apl(corriente_apl1), .frecuencia_apl(frecuencia_apl1),
    .update_strobe(update_strobe1), .busy(busy1), .at_target(at_target1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pe_pulse;
    cyc(1);
    period_end = 1'b1;
    cyc(1);
    period_end = 1'b0;
  endtask

  task automatic pe1_pulse;
    cyc(1);
    period_end1 = 1'b1;
    cyc(1);
    period_end1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++; if (corriente_apl !== 3'd0) begin errors++; $display("FAIL reset_corr got=%0d exp=0", corriente_apl); end
    checks++; if (frecuencia_apl !== 3'd0) begin errors++; $display("FAIL reset_freq got=%0d exp=0", frecuencia_apl); end
    checks++; if ({update_strobe, busy, at_target} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {update_strobe, busy, at_target}); end
    checks++; if ({corriente_apl1, update_strobe1, busy1, at_target1} !== 6'd0) begin errors++; $display("FAIL reset_dut1 got=%b exp=0", {corriente_apl1, update_strobe1, busy1, at_target1}); end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    checks++; if ({busy, at_target} !== 2'b00) begin errors++; $display("FAIL reset_idle got=%b exp=00", {busy, at_target}); end
  endtask

  task automatic test_soft_start;
    int strobes;
    strobes = 0;
    enable = 1'b1; corriente_req = 3'd5; frecuencia_req = 3'd0;
    cyc(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
    for (int k = 1; k <= 10; k++) begin
      pe_pulse();
      checks++; if (corriente_apl !== 3'(k / 2)) begin errors++; $display("FAIL start_corr pe=%0d got=%0d exp=%0d", k, corriente_apl, k / 2); end
      checks++; if (update_strobe !== 1'((k % 2) == 0)) begin errors++; $display("FAIL start_strobe pe=%0d got=%b exp=%b", k, update_strobe, (k % 2) == 0); end
      if (update_strobe === 1'b1) strobes++;
    end
    checks++; if (strobes != 5) begin errors++; $display("FAIL start_strobe_count got=%0d exp=5", strobes); end
    cyc(1);
    checks++; if ({at_target, busy} !== 2'b10) begin errors++; $display("FAIL start_track got=%b exp=10", {at_target, busy}); end
    checks++; if (update_strobe !== 1'b0) begin errors++; $display("FAIL start_strobe_idle got=%b exp=0", update_strobe); end
  endtask

  task automatic test_freq_change;
    frecuencia_req = 3'd3;
    cyc(1);
    checks++; if ({busy, at_target} !== 2'b10) begin errors++; $display("FAIL drain_enter got=%b exp=10", {busy, at_target}); end
    for (int k = 1; k <= 10; k++) begin
      pe_pulse();
      checks++; if (corriente_apl !== 3'(5 - k / 2)) begin errors++; $display("FAIL drain_corr pe=%0d got=%0d exp=%0d", k, corriente_apl, 5 - k / 2); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy pe=%0d got=%b exp=1", k, busy); end
    end
    cyc(1);
    checks++; if (frecuencia_apl !== 3'd0) begin errors++; $display("FAIL switch_wait got=%0d exp=0", frecuencia_apl); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL switch_busy got=%b exp=1", busy); end
    pe_pulse();
    checks++; if (frecuencia_apl !== 3'd3) begin errors++; $display("FAIL switch_freq got=%0d exp=3", frecuencia_apl); end
    checks++; if (update_strobe !== 1'b1) begin errors++; $display("FAIL switch_strobe got=%b exp=1", update_strobe); end
    for (int k = 1; k <= 10; k++) begin
      pe_pulse();
      checks++; if (corriente_apl !== 3'(k / 2)) begin errors++; $display("FAIL reramp_corr pe=%0d got=%0d exp=%0d", k, corriente_apl, k / 2); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reramp_busy pe=%0d got=%b exp=1", k, busy); end
    end
    cyc(1);
    checks++; if ({at_target, busy} !== 2'b10) begin errors++; $display("FAIL reramp_track got=%b exp=10", {at_target, busy}); end
  endtask

  task automatic test_disable_mid_ramp;
    enable = 1'b0;
    cyc(1);
    checks++; if (corriente_apl !== 3'd0) begin errors++; $display("FAIL dis_corr got=%0d exp=0", corriente_apl); end
    checks++; if (update_strobe !== 1'b1) begin errors++; $display("FAIL dis_strobe got=%b exp=1", update_strobe); end
    enable = 1'b1; corriente_req = 3'd6;
    cyc(1);
    for (int k = 1; k <= 7; k++) pe_pulse();
    checks++; if (corriente_apl !== 3'd3) begin errors++; $display("FAIL dis_setup got=%0d exp=3", corriente_apl); end
    cyc(1);
    period_end = 1'b1;
    enable = 1'b0;
    cyc(1);
    period_end = 1'b0;
    checks++; if (corriente_apl !== 3'd0) begin errors++; $display("FAIL dis_step_corr got=%0d exp=0", corriente_apl); end
    checks++; if (frecuencia_apl !== 3'd3) begin errors++; $display("FAIL dis_freq got=%0d exp=3", frecuencia_apl); end
    checks++; if ({busy, at_target, update_strobe} !== 3'b001) begin errors++; $display("FAIL dis_flags got=%b exp=001", {busy, at_target, update_strobe}); end
    cyc(1);
    checks++; if ({busy, update_strobe, corriente_apl} !== 5'd0) begin errors++; $display("FAIL dis_hold got=%b exp=0", {busy, update_strobe, corriente_apl}); end
  endtask

  task automatic test_reverse;
    enable = 1'b1;
    cyc(1);
    for (int k = 1; k <= 4; k++) pe_pulse();
    checks++; if (corriente_apl !== 3'd2) begin errors++; $display("FAIL rev_setup got=%0d exp=2", corriente_apl); end
    corriente_req = 3'd1;
    pe_pulse();
    checks++; if (corriente_apl !== 3'd2) begin errors++; $display("FAIL rev_nostep got=%0d exp=2", corriente_apl); end
    pe_pulse();
    checks++; if (corriente_apl !== 3'd1) begin errors++; $display("FAIL rev_step got=%0d exp=1", corriente_apl); end
    checks++; if (update_strobe !== 1'b1) begin errors++; $display("FAIL rev_strobe got=%b exp=1", update_strobe); end
    cyc(1);
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL rev_track got=%b exp=1", at_target); end
    pe_pulse();
    pe_pulse();
    checks++; if ({corriente_apl, update_strobe} !== {3'd1, 1'b0}) begin errors++; $display("FAIL rev_overshoot got=%0d/%b exp=1/0", corriente_apl, update_strobe); end
  endtask

  task automatic test_async_reset;
    frecuencia_req = 3'd2; corriente_req = 3'd4;
    cyc(1);
    for (int k = 1; k <= 2; k++) pe_pulse();
    pe_pulse();
    checks++; if (frecuencia_apl !== 3'd2) begin errors++; $display("FAIL ar_freq_setup got=%0d exp=2", frecuencia_apl); end
    for (int k = 1; k <= 8; k++) pe_pulse();
    checks++; if (corriente_apl !== 3'd4) begin errors++; $display("FAIL ar_corr_setup got=%0d exp=4", corriente_apl); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({corriente_apl, frecuencia_apl} !== 6'd0) begin errors++; $display("FAIL ar_levels got=%0d/%0d exp=0/0", corriente_apl, frecuencia_apl); end
    checks++; if ({update_strobe, busy, at_target} !== 3'b000) begin errors++; $display("FAIL ar_flags got=%b exp=000", {update_strobe, busy, at_target}); end
    enable = 1'b0;
    #1;
    rst = 1'b0;
    cyc(2);
    checks++; if ({busy, at_target, corriente_apl, frecuencia_apl} !== 8'd0) begin errors++; $display("FAIL ar_idle got=%b exp=0", {busy, at_target, corriente_apl, frecuencia_apl}); end
  endtask

  task automatic test_single_period_ramp;
    int strobes;
    strobes = 0;
    enable1 = 1'b1; corriente_req1 = 3'd0; frecuencia_req1 = 3'd0;
    cyc(2);
    checks++; if (at_target1 !== 1'b1) begin errors++; $display("FAIL rp1_track got=%b exp=1", at_target1); end
    corriente_req1 = 3'(LEVEL_MAX);
    cyc(1);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rp1_busy got=%b exp=1", busy1); end
    for (int k = 1; k <= 7; k++) begin
      pe1_pulse();
      checks++; if (corriente_apl1 !== 3'(k)) begin errors++; $display("FAIL rp1_corr pe=%0d got=%0d exp=%0d", k, corriente_apl1, k); end
      if (update_strobe1 === 1'b1) strobes++;
    end
    checks++; if (strobes != 7) begin errors++; $display("FAIL rp1_strobe_count got=%0d exp=7", strobes); end
    cyc(1);
    checks++; if (at_target1 !== 1'b1) begin errors++; $display("FAIL rp1_final_track got=%b exp=1", at_target1); end
    pe1_pulse();
    checks++; if ({corriente_apl1, update_strobe1} !== {3'd7, 1'b0}) begin errors++; $display("FAIL rp1_saturate got=%0d/%b exp=7/0", corriente_apl1, update_strobe1); end
  endtask

  initial begin
    enable = 1'b0; period_end = 1'b0; corriente_req = '0; frecuencia_req = '0;
    enable1 = 1'b0; period_end1 = 1'b0; corriente_req1 = '0; frecuencia_req1 = '0;
    rst = 1'b0;
    test_reset();
    test_soft_start();
    test_freq_change();
    test_disable_mid_ramp();
    test_reverse();
    test_async_reset();
    test_single_period_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
